// File: rtl/snake_body_reader_pkg.sv
// Shared snake body definitions: scan-reader state encoding and default geometry.
// Imported by the body shifter, the reader and the VGA plotter.
package snake_body_reader_pkg;

  localparam int XW_DEF      = 8;
  localparam int YW_DEF      = 7;
  localparam int MAX_LEN_DEF = 5;
  localparam int LW_DEF      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/snake_seg_mux.sv
// Index-to-slice mux over packed X/Y body vectors (slice 0 = head in the MSBs).
// Purely combinational, zero latency, no flow control; out-of-range index yields 0.
module snake_seg_mux #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int MAX_LEN = 5,
  parameter int LW      = 3
) (
  input  logic [XW*MAX_LEN-1:0] i_x_body,
  input  logic [YW*MAX_LEN-1:0] i_y_body,
  input  logic [LW-1:0]         i_idx,
  output logic [XW-1:0]         o_x,
  output logic [YW-1:0]         o_y
);

  always_comb begin
    o_x = '0;
    o_y = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i_idx == LW'(i)) begin
        o_x = i_x_body[XW*(MAX_LEN-i)-1 -: XW];
        o_y = i_y_body[YW*(MAX_LEN-i)-1 -: YW];
      end
    end
  end

endmodule

// File: rtl/snake_body_reader.sv
// Snapshots the snake body on start and emits one segment per valid/ready handshake, flagging self-collision.
// First segment one cycle after start; segments hold while seg_ready is low; start is ignored unless idle.
module snake_body_reader
  import snake_body_reader_pkg::*;
#(
  parameter int XW      = XW_DEF,
  parameter int YW      = YW_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LW      = LW_DEF
) (
  input  logic                  CLOCK_50,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic [LW-1:0]         length,
  input  logic [XW*MAX_LEN-1:0] x_body,
  input  logic [YW*MAX_LEN-1:0] y_body,
  input  logic                  seg_ready,
  output logic                  seg_valid,
  output logic [XW-1:0]         seg_x,
  output logic [YW-1:0]         seg_y,
  output logic [LW-1:0]         seg_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  collide
);

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic [XW*MAX_LEN-1:0] r_x_snap;
  logic [YW*MAX_LEN-1:0] r_y_snap;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_idx;
  logic                  r_collide;

  logic [LW-1:0]         w_len_clamp;
  logic [XW-1:0]         w_mux_x;
  logic [YW-1:0]         w_mux_y;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_hit;

  assign w_len_clamp = (length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : length;
  assign w_accept    = (r_state == ST_SCAN) && seg_ready;
  assign w_last      = (r_idx == r_len - 1'b1);
  assign w_hit       = (w_mux_x == r_x_snap[XW*MAX_LEN-1 -: XW]) &&
                       (w_mux_y == r_y_snap[YW*MAX_LEN-1 -: YW]);

  snake_seg_mux #(
    .XW      (XW),
    .YW      (YW),
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_seg_mux (
    .i_x_body (r_x_snap),
    .i_y_body (r_y_snap),
    .i_idx    (r_idx),
    .o_x      (w_mux_x),
    .o_y      (w_mux_y)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (w_len_clamp != '0) ? ST_SCAN : ST_DONE;
      ST_SCAN: if (seg_ready && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot decouples the scan from the body shifter advancing underneath it.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_x_snap  <= '0;
      r_y_snap  <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_collide <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_x_snap  <= x_body;
      r_y_snap  <= y_body;
      r_len     <= w_len_clamp;
      r_idx     <= '0;
      r_collide <= 1'b0;
    end else if (w_accept) begin
      if ((r_idx != '0) && w_hit) r_collide <= 1'b1;
      if (!w_last) r_idx <= r_idx + 1'b1;
    end
  end

  assign seg_valid = (r_state == ST_SCAN);
  assign seg_x     = seg_valid ? w_mux_x : '0;
  assign seg_y     = seg_valid ? w_mux_y : '0;
  assign seg_idx   = seg_valid ? r_idx : '0;
  assign busy      = (r_state == ST_SCAN);
  assign done      = (r_state == ST_DONE);
  assign collide   = r_collide;

endmodule
